gr_heep_rr_xbar: RTL and testbench
==================================

# gr_heep_rr_xbar

Parametrised N-master / M-slave OBI crossbar for the GR-HEEP external bus, successor to the fixed X-HEEP external crossbar. It sits between the X-HEEP master ports plus the external masters and the external slaves. It adds three things:
- per-slave round-robin arbitration;
- per-master outstanding-transaction limiting with in-order response routing;
- an optional built-in error responder for unmapped addresses.

## Interface
Parameters:
- NMASTER, 4, number of OBI master ports (≥1)
- NSLAVE, 2, number of OBI slave ports (≥1)
- NUM_RULES, 2, number of address-map rules
- MAX_OUTSTANDING, 2, max un-responded grants per master (≥1)
- SLV_FIFO_DEPTH, 4, per-slave master-index tracking FIFO depth (power of 2, ≥2)
- IdxWidth, localparam, cf_math_pkg::idx_width(NSLAVE)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low
- addr_map_i  in  addr_map_rule_t[NUM_RULES]  rules {idx, start_addr, end_addr}
- default_idx_i  in  IdxWidth  slave for unmatched addresses
- master_req_i  in  obi_req_t[NMASTER]  master requests
- master_resp_o  out  obi_resp_t[NMASTER]  gnt/rvalid/rdata to masters
- slave_req_o  out  obi_req_t[NSLAVE]  requests to slaves
- slave_resp_i  in  obi_resp_t[NSLAVE]  slave responses

## Operation
- Decode: addr matches a rule when start_addr ≤ addr < end_addr, unsigned 32-bit compare. The lowest-index matching rule wins. No match → default_idx_i.
- Eligibility: a master is eligible for its target slave only if all of the following hold:
  - req=1;
  - its outstanding count < MAX_OUTSTANDING;
  - it has zero outstanding transactions, or its last granted slave equals the new target (no cross-slave outstanding, so responses stay in order);
  - the target slave's FIFO is not full.
- Arbitration: per-slave round-robin over eligible masters. The search starts at pointer rr_q[s]. The winner's req/we/be/addr/wdata drive slave_req_o[s]; if none is eligible, slave_req_o[s] is all zeros.
- Grant: master_resp_o[m].gnt = slave_resp_i[s].gnt AND m is the winner of s.
- On a grant:
  - push m into FIFO s;
  - rr_q[s] ← (m+1) mod NMASTER;
  - cnt[m]++;
  - dest[m] ← s.
- If no grant occurs, rr_q[s] holds.
- Response: slave_resp_i[s].rvalid pops FIFO s. The head master h gets rvalid=1 and rdata=slave rdata in the same cycle, and cnt[h]--.
  - A grant and an rvalid for the same master in the same cycle leave cnt unchanged.
  - A push and a pop on the same FIFO in the same cycle are both legal, including when the FIFO is full.
- rvalid on a slave whose FIFO is empty is dropped, and a non-synthesis assertion fires.
- master_resp_o rdata is 0 when rvalid=0.

## Timing
- Zero added latency; all request/gnt/rvalid paths are combinational. State updates happen on posedge clk_i.
- Reset values (async on rst_ni low): cnt=0, dest=0, rr_q=0, all FIFOs empty, error-responder valid=0.
- With all master req=0, every output is 0.
- Reset mid-operation: outstanding tracking is discarded, and late slave rvalids after reset are dropped as described above.
- An OBI master must hold req/addr stable until gnt; the crossbar does not re-arbitrate a held request differently within the cycle.
- FIFO pointers wrap modulo SLV_FIFO_DEPTH. Full is detected with an extra pointer bit.

## Configuration
- GR_HEEP_XBAR_ERR_EN defined:
  - unmatched addresses go to an internal error slave (tracked as index NSLAVE), which always grants;
  - the next cycle it returns rvalid=1 with rdata=32'hBADACCE5;
  - writes are discarded;
  - it uses the same eligibility and round-robin rules, with a tracking FIFO of depth SLV_FIFO_DEPTH;
  - default_idx_i is ignored.
- GR_HEEP_XBAR_ERR_EN undefined: unmatched addresses route to default_idx_i and no error-slave logic is built.

## Test plan
- Rules {0:[0x1000,0x2000), 1:[0x2000,0x3000)}; M0 reads 0x1004, slave 0 gnt same cycle, rvalid 2 cycles later with rdata 0xA5A5A5A5 → M0 gnt at cycle 0, rvalid+0xA5A5A5A5 at cycle 2, cnt returns to 0.
- All four masters hold req to 0x1000 with the slave always granting → grants rotate M0,M1,M2,M3,M0, one per cycle.
- MAX_OUTSTANDING=2; M1 issues 3 reads to slave 1, which withholds rvalid → the third request is not granted until the first rvalid, then it is granted in the same cycle as that rvalid.
- M0 has an outstanding read to slave 0 and requests slave 1 → slave_req_o[1].req=0 until the slave 0 rvalid, then it is granted.
- Read 0x8000 (unmapped), default_idx_i=1, macro off → routed to slave 1. Macro on → gnt in cycle 0, rvalid in cycle 1 with rdata 0xBADACCE5, and no slave sees req.
- Assert rst_ni low with 2 outstanding, release, then drive a stale rvalid on slave 0 → no master rvalid, and new requests are granted normally.

Source files
------------

// File: rtl/gr_heep_rr_xbar.sv
// GR-HEEP external OBI crossbar: round-robin per slave, per-master outstanding limit.
// Define GR_HEEP_XBAR_ERR_EN to build the internal error slave for unmapped addresses.
package gr_heep_xbar_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;
endpackage

module gr_heep_rr_xbar
    import gr_heep_xbar_pkg::*;
#(
    parameter int unsigned NMASTER         = 4,
    parameter int unsigned NSLAVE          = 2,
    parameter int unsigned NUM_RULES       = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned SLV_FIFO_DEPTH  = 4,
    localparam int unsigned IdxWidth = (NSLAVE > 1) ? $clog2(NSLAVE) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  addr_map_rule_t      addr_map_i [NUM_RULES],
    input  logic [IdxWidth-1:0] default_idx_i,
    input  obi_req_t            master_req_i [NMASTER],
    output obi_resp_t           master_resp_o [NMASTER],
    output obi_req_t            slave_req_o [NSLAVE],
    input  obi_resp_t           slave_resp_i [NSLAVE]
);
`ifdef GR_HEEP_XBAR_ERR_EN
    localparam int unsigned NT = NSLAVE + 1;
`else
    localparam int unsigned NT = NSLAVE;
`endif
    localparam int unsigned TW = (NT > 1) ? $clog2(NT) : 1;
    localparam int unsigned MW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FW = $clog2(SLV_FIFO_DEPTH);

    logic [TW-1:0] tgt     [NMASTER];
    logic [CW-1:0] cnt_q   [NMASTER];
    logic [CW-1:0] cnt_eff [NMASTER];
    logic [TW-1:0] dest_q  [NMASTER];
    logic [NMASTER-1:0] inc, dec;

    logic [MW-1:0] rr_q   [NT];
    logic [MW-1:0] fifo_q [NT][SLV_FIFO_DEPTH];
    logic [FW:0]   wptr_q [NT];
    logic [FW:0]   rptr_q [NT];
    logic [MW-1:0] head   [NT];
    logic [MW-1:0] win    [NT];
    logic [31:0]   s_rdata [NT];
    logic [NT-1:0] s_gnt, s_rvalid, empty, full, pop, found, push;
`ifdef GR_HEEP_XBAR_ERR_EN
    logic err_valid_q;
`endif

    // Descending scan so the lowest-index matching rule has the last word.
    always_comb begin
        for (int m = 0; m < NMASTER; m++) begin
`ifdef GR_HEEP_XBAR_ERR_EN
            tgt[m] = TW'(NSLAVE);
`else
            tgt[m] = TW'(default_idx_i);
`endif
            for (int r = NUM_RULES - 1; r >= 0; r--) begin
                if (master_req_i[m].addr >= addr_map_i[r].start_addr &&
                    master_req_i[m].addr < addr_map_i[r].end_addr)
                    tgt[m] = TW'(addr_map_i[r].idx);
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NSLAVE; s++) begin
            s_gnt[s]    = slave_resp_i[s].gnt;
            s_rvalid[s] = slave_resp_i[s].rvalid;
            s_rdata[s]  = slave_resp_i[s].rdata;
        end
`ifdef GR_HEEP_XBAR_ERR_EN
        s_gnt[NSLAVE]    = 1'b1;
        s_rvalid[NSLAVE] = err_valid_q;
        s_rdata[NSLAVE]  = 32'hBADACCE5;
`endif
    end

    always_comb begin
        for (int s = 0; s < NT; s++) begin
            empty[s] = (wptr_q[s] == rptr_q[s]);
            full[s]  = (wptr_q[s][FW] != rptr_q[s][FW]) &&
                       (wptr_q[s][FW-1:0] == rptr_q[s][FW-1:0]);
            pop[s]   = s_rvalid[s] && !empty[s];
            head[s]  = fifo_q[s][rptr_q[s][FW-1:0]];
        end
    end

    // A response retiring this cycle frees its slot for a same-cycle grant.
    always_comb begin
        dec = '0;
        for (int s = 0; s < NT; s++)
            if (pop[s]) dec[head[s]] = 1'b1;
        for (int m = 0; m < NMASTER; m++)
            cnt_eff[m] = cnt_q[m] - CW'(dec[m]);
    end

    always_comb begin
        int idx;
        idx = 0;
        for (int s = 0; s < NT; s++) begin
            found[s] = 1'b0;
            win[s]   = '0;
            for (int k = 0; k < NMASTER; k++) begin
                idx = (int'(rr_q[s]) + k) % NMASTER;
                if (!found[s] && master_req_i[idx].req &&
                    tgt[idx] == TW'(s) &&
                    cnt_eff[idx] < CW'(MAX_OUTSTANDING) &&
                    (cnt_eff[idx] == '0 || dest_q[idx] == TW'(s)) &&
                    (!full[s] || pop[s])) begin
                    found[s] = 1'b1;
                    win[s]   = MW'(idx);
                end
            end
            push[s] = found[s] && s_gnt[s];
        end
    end

    always_comb begin
        inc = '0;
        for (int s = 0; s < NSLAVE; s++) begin
            slave_req_o[s] = '0;
            if (found[s]) slave_req_o[s] = master_req_i[win[s]];
        end
        for (int m = 0; m < NMASTER; m++) begin
            master_resp_o[m] = '0;
            for (int s = 0; s < NT; s++) begin
                if (push[s] && win[s] == MW'(m)) begin
                    master_resp_o[m].gnt = 1'b1;
                    inc[m] = 1'b1;
                end
                if (pop[s] && head[s] == MW'(m)) begin
                    master_resp_o[m].rvalid = 1'b1;
                    master_resp_o[m].rdata  = s_rdata[s];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int m = 0; m < NMASTER; m++) begin
                cnt_q[m]  <= '0;
                dest_q[m] <= '0;
            end
            for (int s = 0; s < NT; s++) begin
                rr_q[s]   <= '0;
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
`ifdef GR_HEEP_XBAR_ERR_EN
            err_valid_q <= 1'b0;
`endif
        end else begin
            for (int s = 0; s < NT; s++) begin
                if (push[s]) begin
                    rr_q[s]   <= MW'((int'(win[s]) + 1) % NMASTER);
                    wptr_q[s] <= wptr_q[s] + 1'b1;
                    dest_q[win[s]] <= TW'(s);
                end
                if (pop[s]) rptr_q[s] <= rptr_q[s] + 1'b1;
            end
            for (int m = 0; m < NMASTER; m++)
                cnt_q[m] <= cnt_q[m] + CW'(inc[m]) - CW'(dec[m]);
`ifdef GR_HEEP_XBAR_ERR_EN
            err_valid_q <= push[NSLAVE];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NT; s++)
            if (push[s]) fifo_q[s][wptr_q[s][FW-1:0]] <= win[s];
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni)
            for (int s = 0; s < NT; s++)
                assert (!(s_rvalid[s] && empty[s]))
                else $warning("xbar: rvalid dropped on slave %0d, no tracked request", s);
    end
`endif
endmodule

// File: tb/tb_gr_heep_rr_xbar.sv
// Directed bench for gr_heep_rr_xbar (4 masters, 2 slaves, 2 outstanding).
module tb_gr_heep_rr_xbar;
    import gr_heep_xbar_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    addr_map_rule_t addr_map [2];
    logic [0:0]     default_idx;
    obi_req_t       mreq  [4];
    obi_resp_t      mresp [4];
    obi_req_t       sreq  [2];
    obi_resp_t      sresp [2];
    int             n_checks = 0;
    int             n_fail = 0;

    gr_heep_rr_xbar dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .addr_map_i    (addr_map),
        .default_idx_i (default_idx),
        .master_req_i  (mreq),
        .master_resp_o (mresp),
        .slave_req_o   (sreq),
        .slave_resp_i  (sresp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gvec();
        gvec = '0;
        for (int m = 0; m < 4; m++) gvec[m] = mresp[m].gnt;
    endfunction

    function automatic logic [31:0] rvec();
        rvec = '0;
        for (int m = 0; m < 4; m++) rvec[m] = mresp[m].rvalid;
    endfunction

    function automatic obi_req_t rd(input logic [31:0] a);
        rd = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0};
    endfunction

    task automatic clear_in();
        for (int m = 0; m < 4; m++) mreq[m] = '0;
        for (int s = 0; s < 2; s++) sresp[s] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        addr_map[0] = '{idx: 32'd0, start_addr: 32'h1000, end_addr: 32'h2000};
        addr_map[1] = '{idx: 32'd1, start_addr: 32'h2000, end_addr: 32'h3000};
        default_idx = 1'b1;
        do_reset();

        // idle outputs after reset
        #1;
        check("rst_gnt", gvec(), 0);
        check("rst_rvalid", rvec(), 0);
        check("rst_sreq0", 32'(sreq[0].req), 0);
        check("rst_sreq1", 32'(sreq[1].req), 0);
        check("rst_rdata", mresp[0].rdata, 0);

        // basic read with 2-cycle response
        step();
        mreq[0] = rd(32'h1004);
        sresp[0].gnt = 1'b1;
        #1;
        check("rd_gnt", gvec(), 32'h1);
        check("rd_sreq", 32'(sreq[0].req), 1);
        check("rd_addr", sreq[0].addr, 32'h1004);
        check("rd_sreq1", 32'(sreq[1].req), 0);
        step();
        clear_in();
        #1;
        check("rd_c1_rvalid", rvec(), 0);
        step();
        sresp[0].rvalid = 1'b1;
        sresp[0].rdata = 32'hA5A5A5A5;
        #1;
        check("rd_c2_rvalid", rvec(), 32'h1);
        check("rd_c2_rdata", mresp[0].rdata, 32'hA5A5A5A5);
        step();
        clear_in();
        mreq[0] = rd(32'h2000);
        sresp[1].gnt = 1'b1;
        #1;
        check("rd_cnt0_gnt", gvec(), 32'h1);
        step();
        clear_in();
        sresp[1].rvalid = 1'b1;
        #1;
        check("rd_s1_rvalid", rvec(), 32'h1);
        step();
        clear_in();

        // round robin over four held requests
        do_reset();
        step();
        for (int m = 0; m < 4; m++) mreq[m] = rd(32'h1000);
        sresp[0].gnt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sresp[0].rvalid = (c > 0);
            #1;
            check($sformatf("rr_gnt%0d", c), gvec(), 32'(1 << (c % 4)));
            if (c > 0)
                check($sformatf("rr_rv%0d", c), rvec(), 32'(1 << ((c - 1) % 4)));
            step();
        end
        clear_in();
        sresp[0].rvalid = 1'b1;
        #1;
        check("rr_drain", rvec(), 32'h1);
        step();
        clear_in();

        // outstanding limit on M1 towards slave 1
        do_reset();
        step();
        mreq[1] = rd(32'h2000);
        sresp[1].gnt = 1'b1;
        #1;
        check("os_gnt0", gvec(), 32'h2);
        step();
        #1;
        check("os_gnt1", gvec(), 32'h2);
        step();
        #1;
        check("os_block_gnt", gvec(), 0);
        check("os_block_req", 32'(sreq[1].req), 0);
        step();
        sresp[1].rvalid = 1'b1;
        sresp[1].rdata = 32'h11;
        #1;
        check("os_rv_gnt", gvec(), 32'h2);
        check("os_rv", rvec(), 32'h2);
        check("os_rdata", mresp[1].rdata, 32'h11);
        step();
        mreq[1] = '0;
        sresp[1].rdata = 32'h22;
        #1;
        check("os_rv2", rvec(), 32'h2);
        check("os_rdata2", mresp[1].rdata, 32'h22);
        step();
        #1;
        check("os_rv3", rvec(), 32'h2);
        step();
        clear_in();

        // no cross-slave outstanding
        do_reset();
        step();
        mreq[0] = rd(32'h1000);
        sresp[0].gnt = 1'b1;
        #1;
        check("xs_gnt0", gvec(), 32'h1);
        step();
        mreq[0] = rd(32'h2000);
        sresp[0].gnt = 1'b0;
        sresp[1].gnt = 1'b1;
        #1;
        check("xs_block_req", 32'(sreq[1].req), 0);
        check("xs_block_gnt", gvec(), 0);
        step();
        sresp[0].rvalid = 1'b1;
        sresp[0].rdata = 32'h33;
        #1;
        check("xs_req", 32'(sreq[1].req), 1);
        check("xs_gnt", gvec(), 32'h1);
        check("xs_rv", rvec(), 32'h1);
        step();
        clear_in();
        sresp[1].rvalid = 1'b1;
        #1;
        check("xs_rv1", rvec(), 32'h1);
        step();
        clear_in();

        // unmapped address
        do_reset();
        step();
        mreq[2] = rd(32'h8000);
`ifdef GR_HEEP_XBAR_ERR_EN
        #1;
        check("err_gnt", gvec(), 32'h4);
        check("err_sreq0", 32'(sreq[0].req), 0);
        check("err_sreq1", 32'(sreq[1].req), 0);
        step();
        clear_in();
        #1;
        check("err_rv", rvec(), 32'h4);
        check("err_rdata", mresp[2].rdata, 32'hBADACCE5);
`else
        sresp[1].gnt = 1'b1;
        #1;
        check("def_gnt", gvec(), 32'h4);
        check("def_sreq1", 32'(sreq[1].req), 1);
        check("def_addr", sreq[1].addr, 32'h8000);
        check("def_sreq0", 32'(sreq[0].req), 0);
        step();
        clear_in();
        sresp[1].rvalid = 1'b1;
        sresp[1].rdata = 32'h44;
        #1;
        check("def_rv", rvec(), 32'h4);
        check("def_rdata", mresp[2].rdata, 32'h44);
`endif
        step();
        clear_in();

        // reset with two outstanding, then stale rvalid
        do_reset();
        step();
        mreq[0] = rd(32'h1000);
        mreq[1] = rd(32'h1000);
        sresp[0].gnt = 1'b1;
        #1;
        check("mr_gnt0", gvec(), 32'h1);
        step();
        mreq[0] = '0;
        #1;
        check("mr_gnt1", gvec(), 32'h2);
        step();
        clear_in();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        sresp[0].rvalid = 1'b1;
        sresp[0].rdata = 32'h55;
        #1;
        check("mr_stale", rvec(), 0);
        step();
        clear_in();
        mreq[0] = rd(32'h1000);
        sresp[0].gnt = 1'b1;
        #1;
        check("mr_new_gnt", gvec(), 32'h1);
        step();
        clear_in();
        sresp[0].rvalid = 1'b1;
        sresp[0].rdata = 32'h66;
        #1;
        check("mr_new_rv", rvec(), 32'h1);
        check("mr_new_rdata", mresp[0].rdata, 32'h66);
        step();
        clear_in();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
